ysyx_23060332_dmem_resp: RTL and testbench



---
 rtl/ysyx_23060332_dmem_resp.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_23060332_dmem_resp.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_dmem_resp.sv
// Data memory with fixed request-to-response latency and a valid/ready response handshake.
// One request is in flight at a time; its address, data, mask and op type are captured at accept.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request (mem_ready high once out of reset)
// WAIT  | latency down-counter running; RESP is entered when it reaches 0
// RESP  | response presented; held until mem_rready is seen
module ysyx_23060332_dmem_resp #(
    parameter int          LATENCY = 2,
    parameter int          DEPTH   = 1024,
    parameter logic [31:0] BASE    = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_raddr,
    input  logic [31:0] mem_waddr,
    input  logic [31:0] mem_wdata,
    input  logic [7:0]  mem_wmask,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_rvalid,
    output logic        mem_rwrite,
    output logic        mem_rerr,
    input  logic        mem_rready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wmask_q, wmask_d;
    logic               wr_q, wr_d;
    logic               both_q, both_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rerr_q, rerr_d;
    logic               rwrite_q, rwrite_d;

    logic [31:0]        mem_q [DEPTH];

    logic               accept;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic [3:0]         cur_mask;
    logic               cur_wr;
    logic               cur_both;
    logic [31:0]        offset;
    logic               addr_ok;
    logic [IDX_W-1:0]   idx;
    logic               enter_resp;
    logic               mem_we;
    logic               unused_wmask_hi;

    assign unused_wmask_hi = ^mem_wmask[7:4];

    // Operation being resolved: live inputs when a LATENCY==1 accept goes straight to RESP,
    // otherwise the copy captured at accept.
    always_comb begin
        accept     = ready_q & (mem_ren | mem_wen);
        cur_addr   = addr_q;
        cur_wdata  = wdata_q;
        cur_mask   = wmask_q;
        cur_wr     = wr_q;
        cur_both   = both_q;
        if (state_q == IDLE) begin
            cur_addr  = mem_wen ? mem_waddr : mem_raddr;
            cur_wdata = mem_wdata;
            cur_mask  = mem_wmask[3:0];
            cur_wr    = mem_wen;
            cur_both  = mem_ren & mem_wen;
        end
        offset     = cur_addr - BASE;
        addr_ok    = (cur_addr[1:0] == 2'b00) && (cur_addr >= BASE) && ((offset >> 2) < 32'(DEPTH));
        idx        = offset[IDX_W+1:2];
        enter_resp = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                     ((state_q == WAIT) && (cnt_q == '0));
        mem_we     = enter_resp & cur_wr & addr_ok;
    end

    // Next-state, capture and response computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        wr_d     = wr_q;
        both_d   = both_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rerr_d   = rerr_q;
        rwrite_d = rwrite_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    addr_d  = cur_addr;
                    wdata_d = cur_wdata;
                    wmask_d = cur_mask;
                    wr_d    = cur_wr;
                    both_d  = cur_both;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (mem_rready) begin
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    rvalid_d = 1'b0;
                    rdata_d  = '0;
                    rerr_d   = 1'b0;
                    rwrite_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (enter_resp) begin
            rvalid_d = 1'b1;
            rwrite_d = cur_wr;
            rerr_d   = cur_both | ~addr_ok;
            rdata_d  = (cur_wr | ~addr_ok) ? 32'h0 : mem_q[idx];
        end
    end

    // Control and response registers; async reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            wr_q     <= 1'b0;
            both_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
            rwrite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            wr_q     <= wr_d;
            both_q   <= both_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
            rwrite_q <= rwrite_d;
        end
    end

    // Storage array, byte-masked write on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_mask[i]) begin
                    mem_q[idx][i*8 +: 8] <= cur_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign mem_ready  = ready_q;
    assign mem_rvalid = rvalid_q;
    assign mem_rdata  = rdata_q;
    assign mem_rerr   = rerr_q;
    assign mem_rwrite = rwrite_q;

endmodule

// File: tb/tb_ysyx_23060332_dmem_resp.sv
// Self-checking bench: directed vector table, reset corner sequences, then random ops vs a word model.
module tb_ysyx_23060332_dmem_resp;

    localparam int          LAT   = 2;
    localparam int          DEP   = 1024;
    localparam logic [31:0] BASEA = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ren, mem_wen, mem_rready;
    logic [31:0] mem_raddr, mem_waddr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready, mem_rvalid, mem_rwrite, mem_rerr;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060332_dmem_resp #(.LATENCY(LAT), .DEPTH(DEP), .BASE(BASEA)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid), .mem_rwrite(mem_rwrite),
        .mem_rerr(mem_rerr), .mem_rready(mem_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [31:0] raddr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [7:0]  mask;
        int          hold;
        logic [31:0] e_data;
        logic        e_err;
        logic        e_rw;
    } vec_t;

    vec_t vecs[$];
    bit [31:0] mdl [int];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_op(input string name, input logic ren, input logic wen,
                         input logic [31:0] raddr, input logic [31:0] waddr,
                         input logic [31:0] wdata, input logic [7:0] mask, input int hold,
                         input logic [31:0] e_data, input logic e_err, input logic e_rw,
                         input bit chk_data);
        int n;
        n = 0;
        while (!mem_ready && n < 20) begin
            tick();
            n++;
        end
        check({name, "/ready"}, 32'(mem_ready), 32'd1);
        mem_ren    = ren;
        mem_wen    = wen;
        mem_raddr  = raddr;
        mem_waddr  = waddr;
        mem_wdata  = wdata;
        mem_wmask  = mask;
        mem_rready = 1'b0;
        tick();
        // Scramble captured fields; ready is low now so nothing new can be accepted.
        mem_ren   = 1'($urandom);
        mem_wen   = 1'($urandom);
        mem_raddr = $urandom;
        mem_waddr = $urandom;
        mem_wdata = $urandom;
        mem_wmask = 8'($urandom);
        n = 1;
        while (!mem_rvalid && n < 20) begin
            tick();
            n++;
        end
        mem_ren = 1'b0;
        mem_wen = 1'b0;
        check({name, "/latency"}, 32'(n), 32'(LAT));
        check({name, "/rwrite"}, 32'(mem_rwrite), 32'(e_rw));
        check({name, "/rerr"}, 32'(mem_rerr), 32'(e_err));
        if (chk_data) check({name, "/rdata"}, mem_rdata, e_data);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, "/hold_rvalid"}, 32'(mem_rvalid), 32'd1);
            check({name, "/hold_ready"}, 32'(mem_ready), 32'd0);
            if (chk_data) check({name, "/hold_rdata"}, mem_rdata, e_data);
        end
        mem_rready = 1'b1;
        tick();
        check({name, "/done_rvalid"}, 32'(mem_rvalid), 32'd0);
        check({name, "/done_ready"}, 32'(mem_ready), 32'd1);
        check({name, "/done_flags"}, {30'd0, mem_rerr, mem_rwrite}, 32'd0);
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASEA);
        return (a % 4 == 0) && (off >= 0) && (off / 4 < DEP);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASEA)) / 4);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = BASEA + 32'($urandom_range(0, 15)) * 4;
        case ($urandom_range(0, 9))
            0: a = BASEA - 32'd4;
            1: a = BASEA + 32'(DEP * 4);
            2: a = a + 32'($urandom_range(1, 3));
            default: ;
        endcase
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mem_ren = 0; mem_wen = 0; mem_rready = 0;
        mem_raddr = 0; mem_waddr = 0; mem_wdata = 0; mem_wmask = 0;
        repeat (3) tick();
        check("rst/ready", 32'(mem_ready), 32'd0);
        check("rst/rvalid", 32'(mem_rvalid), 32'd0);
        check("rst/rdata", mem_rdata, 32'd0);
        check("rst/flags", {30'd0, mem_rerr, mem_rwrite}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_rel/ready_low", 32'(mem_ready), 32'd0);
        tick();
        check("rst_rel/ready_high", 32'(mem_ready), 32'd1);

        // ren, wen, raddr, waddr, wdata, mask, hold, e_data, e_err, e_rw
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 0, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 8'h00, 5, 32'hDEAD_BEEF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h8000_0010, 32'h1122_3344, 8'h05, 0, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 8'h00, 1, 32'hDE22_BE44, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h8000_0FFC, 32'h0BAD_CAFE, 8'h0F, 0, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h8000_0000, 32'h0000_1111, 8'h0F, 0, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0, 8'h00, 0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_1000, 32'h0, 32'h0, 8'h00, 2, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 8'h00, 0, 32'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0FFC, 32'h0, 32'h0, 8'h00, 0, 32'h0BAD_CAFE, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 8'h00, 0, 32'hDE22_BE44, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h8000_1000, 32'hFFFF_FFFF, 8'h0F, 0, 32'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 8'h00, 0, 32'h0000_1111, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 32'h8000_0010, 32'h8000_0030, 32'hA5A5_A5A5, 8'h0F, 0, 32'h0, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0030, 32'h0, 32'h0, 8'h00, 0, 32'hA5A5_A5A5, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h8000_0030, 32'h1234_5678, 8'hF0, 0, 32'h0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 32'h8000_0030, 32'h0, 32'h0, 8'h00, 0, 32'hA5A5_A5A5, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 32'h0, 32'h8000_0020, 32'h0101_0101, 8'h0F, 0, 32'h0, 1'b0, 1'b1});

        foreach (vecs[i]) begin
            do_op($sformatf("vec%0d", i), vecs[i].ren, vecs[i].wen, vecs[i].raddr, vecs[i].waddr,
                  vecs[i].wdata, vecs[i].mask, vecs[i].hold, vecs[i].e_data, vecs[i].e_err,
                  vecs[i].e_rw, 1'b1);
        end

        // Reset while a write waits: the write must not land.
        mem_wen = 1'b1; mem_ren = 1'b0;
        mem_waddr = 32'h8000_0020; mem_wdata = 32'hFFFF_FFFF; mem_wmask = 8'h0F;
        tick();
        mem_wen = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_wait/ready", 32'(mem_ready), 32'd0);
        check("rst_wait/rvalid", 32'(mem_rvalid), 32'd0);
        tick();
        check("rst_wait/no_resp", 32'(mem_rvalid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_wait/ready_low", 32'(mem_ready), 32'd0);
        tick();
        check("rst_wait/ready_high", 32'(mem_ready), 32'd1);
        check("rst_wait/still_none", 32'(mem_rvalid), 32'd0);
        do_op("rst_wait_rd", 1'b1, 1'b0, 32'h8000_0020, 32'h0, 32'h0, 8'h0, 0,
              32'h0101_0101, 1'b0, 1'b0, 1'b1);

        // Reset while a response is presented: response vanishes without handshake.
        mem_ren = 1'b1; mem_raddr = 32'h8000_0020; mem_rready = 1'b0;
        tick();
        mem_ren = 1'b0;
        for (int i = 0; i < 20 && !mem_rvalid; i++) tick();
        check("rst_resp/rvalid", 32'(mem_rvalid), 32'd1);
        check("rst_resp/rdata", mem_rdata, 32'h0101_0101);
        rst_n = 1'b0;
        #1;
        check("rst_resp/rvalid_drop", 32'(mem_rvalid), 32'd0);
        check("rst_resp/rdata_zero", mem_rdata, 32'd0);
        check("rst_resp/ready", 32'(mem_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_resp/ready_back", 32'(mem_ready), 32'd1);
        check("rst_resp/idle", 32'(mem_rvalid), 32'd0);

        // Random traffic against the word model; window first filled with known data.
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, d;
            a = BASEA + 32'(i * 4);
            d = $urandom;
            mdl[word_of(a)] = d;
            do_op($sformatf("init%0d", i), 1'b0, 1'b1, 32'h0, a, d, 8'h0F, 0, 32'h0, 1'b0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 60; i++) begin
            logic        ren, wen, ok, e_err;
            logic [31:0] ra, wa, wd, a, e_data;
            logic [7:0]  mk;
            bit          known;
            int          w;
            case ($urandom_range(0, 4))
                0, 1: begin ren = 1'b1; wen = 1'b0; end
                2, 3: begin ren = 1'b0; wen = 1'b1; end
                default: begin ren = 1'b1; wen = 1'b1; end
            endcase
            ra = rand_addr();
            wa = rand_addr();
            wd = $urandom;
            mk = 8'($urandom);
            a  = wen ? wa : ra;
            ok = addr_valid(a);
            e_err  = (ren & wen) | ~ok;
            e_data = 32'h0;
            known  = 1'b1;
            if (ok) begin
                w = word_of(a);
                if (wen) begin
                    for (int b = 0; b < 4; b++)
                        if (mk[b]) mdl[w][b*8 +: 8] = wd[b*8 +: 8];
                end else if (mdl.exists(w)) begin
                    e_data = mdl[w];
                end else begin
                    known = 1'b0;
                end
            end
            do_op($sformatf("rnd%0d", i), ren, wen, ra, wa, wd, mk, int'($urandom_range(0, 2)),
                  e_data, e_err, wen, known);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
